// File: rtl/sorted_vector_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sorted_vector_serializer_if                                          |
// | Word stream out of the serializer: data, valid, ready, last marker.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sorted_vector_serializer_if #(
   parameter int NUMBER_WIDTH = 10
) ();
   logic [NUMBER_WIDTH-1:0] data_o;
   logic                    data_valid_o;
   logic                    data_ready_i;
   logic                    data_last_o;

   modport master (
      output data_o,
      output data_valid_o,
      output data_last_o,
      input  data_ready_i
   );

   modport slave (
      input  data_o,
      input  data_valid_o,
      input  data_last_o,
      output data_ready_i
   );
endinterface
`default_nettype wire

// File: rtl/sorted_vector_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sorted_vector_serializer                                             |
// | Streams a parallel sorted vector one word per handshake, with an     |
// | active + pending slot. SORTED_VECTOR_SERIALIZER_REVERSE_EN: descend. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sorted_vector_serializer #(
   parameter int NUMBER_WIDTH   = 10,
   parameter int NUMBERS_AMOUNT = 10
) (
   input  wire                                         clk_i,
   input  wire                                         rst_i,
   input  wire [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  data_i,
   input  wire                                         data_valid_i,
   sorted_vector_serializer_if.master                  out_if,
   output logic                                        busy_o,
   output logic                                        overflow_o
);
   localparam int                IDX_W    = $clog2(NUMBERS_AMOUNT);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUMBERS_AMOUNT - 1);

   typedef logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] vec_t;

   vec_t                    active_q, active_d;
   vec_t                    pending_q, pending_d;
   logic                    active_valid_q, active_valid_d;
   logic                    pending_valid_q, pending_valid_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUMBER_WIDTH-1:0] data_q, data_d;
   logic                    last_q, last_d;
   logic                    overflow_q, overflow_d;

   logic                    xfer;
   logic                    last_xfer;
   logic [IDX_W-1:0]        sel_idx;

   always_comb begin
      active_d        = active_q;
      pending_d       = pending_q;
      active_valid_d  = active_valid_q;
      pending_valid_d = pending_valid_q;
      idx_d           = idx_q;
      data_d          = data_q;
      last_d          = last_q;
      overflow_d      = overflow_q;
      sel_idx         = '0;

      xfer      = active_valid_q && out_if.data_ready_i;
      last_xfer = xfer && (idx_q == LAST_IDX);

      // Release/refill is resolved first so a same-cycle strobe sees the freed slot.
      if (last_xfer) begin
         idx_d = '0;
         if (pending_valid_q) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
         end else begin
            active_valid_d  = 1'b0;
         end
      end else if (xfer) begin
         idx_d = idx_q + 1'b1;
      end

      if (data_valid_i) begin
         if (!active_valid_d) begin
            active_d       = data_i;
            active_valid_d = 1'b1;
            idx_d          = '0;
         end else if (!pending_valid_d) begin
            pending_d       = data_i;
            pending_valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end

`ifdef SORTED_VECTOR_SERIALIZER_REVERSE_EN
      sel_idx = LAST_IDX - idx_d;
`else
      sel_idx = idx_d;
`endif

      // Output word is registered from next-state so it never follows data_i combinationally.
      if (active_valid_d) begin
         data_d = active_d[sel_idx];
         last_d = (idx_d == LAST_IDX);
      end else begin
         last_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active_q        <= '0;
         pending_q       <= '0;
         active_valid_q  <= 1'b0;
         pending_valid_q <= 1'b0;
         idx_q           <= '0;
         data_q          <= '0;
         last_q          <= 1'b0;
         overflow_q      <= 1'b0;
      end else begin
         active_q        <= active_d;
         pending_q       <= pending_d;
         active_valid_q  <= active_valid_d;
         pending_valid_q <= pending_valid_d;
         idx_q           <= idx_d;
         data_q          <= data_d;
         last_q          <= last_d;
         overflow_q      <= overflow_d;
      end
   end

   assign out_if.data_o       = data_q;
   assign out_if.data_valid_o = active_valid_q;
   assign out_if.data_last_o  = last_q;
   assign busy_o              = active_valid_q | pending_valid_q;
   assign overflow_o          = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_sorted_vector_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sorted_vector_serializer                                          |
// | Directed bench for sorted_vector_serializer (both word orders).      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sorted_vector_serializer;
   localparam int NW = 10;
   localparam int NA = 10;

   typedef logic [NA-1:0][NW-1:0] vec_t;

   logic   clk_i;
   logic   rst_i;
   vec_t   data_i;
   logic   data_valid_i;
   logic   busy_o;
   logic   overflow_o;
   int     n_checks;
   int     n_pass;

   sorted_vector_serializer_if #(.NUMBER_WIDTH(NW)) bus ();

   sorted_vector_serializer #(
      .NUMBER_WIDTH   (NW),
      .NUMBERS_AMOUNT (NA)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .data_i       (data_i),
      .data_valid_i (data_valid_i),
      .out_if       (bus),
      .busy_o       (busy_o),
      .overflow_o   (overflow_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic vec_t mkvec(input int base);
      vec_t v;
      for (int i = 0; i < NA; i++) v[i] = NW'(base + i);
      return v;
   endfunction

   // Offset of the k-th emitted word within its vector.
   function automatic int ord(input int k);
`ifdef SORTED_VECTOR_SERIALIZER_REVERSE_EN
      return NA - 1 - k;
`else
      return k;
`endif
   endfunction

   task automatic do_reset();
      rst_i        = 1'b1;
      data_valid_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic strobe(input int base);
      data_i       = mkvec(base);
      data_valid_i = 1'b1;
      tick();
      data_valid_i = 1'b0;
   endtask

   // Expects n consecutive valid words (ready held high); optionally strobes a new vector at word strobe_at.
   task automatic stream(input string t, input int base, input int n, input int strobe_at, input int sbase);
      for (int k = 0; k < n; k++) begin
         if (k == strobe_at) begin
            data_i       = mkvec(sbase);
            data_valid_i = 1'b1;
         end
         check($sformatf("%s.valid[%0d]", t, k), bus.data_valid_o, 1);
         check($sformatf("%s.data[%0d]", t, k), bus.data_o, base + ord(k));
         check($sformatf("%s.last[%0d]", t, k), bus.data_last_o, (k == NA - 1));
         tick();
         data_valid_i = 1'b0;
      end
   endtask

   initial begin
      int               k;
      int               cyc;
      logic             held_v;
      logic [NW-1:0]    held_d;
      logic             held_l;

      n_checks         = 0;
      n_pass           = 0;
      rst_i            = 1'b1;
      data_i           = '0;
      data_valid_i     = 1'b0;
      bus.data_ready_i = 1'b1;

      // Reset state
      do_reset();
      check("rst.valid", bus.data_valid_o, 0);
      check("rst.data", bus.data_o, 0);
      check("rst.last", bus.data_last_o, 0);
      check("rst.busy", busy_o, 0);
      check("rst.ovf", overflow_o, 0);

      // Single vector, ready high
      strobe(0);
      stream("t1", 0, NA, -1, 0);
      check("t1.valid_end", bus.data_valid_o, 0);
      check("t1.last_end", bus.data_last_o, 0);
      check("t1.busy_end", busy_o, 0);

      // Ready toggling: words held while stalled
      strobe(0);
      k      = 0;
      cyc    = 0;
      held_v = 1'b0;
      held_d = '0;
      held_l = 1'b0;
      while (k < NA && cyc < 100) begin
         if (held_v) begin
            check("t2.hold_data", bus.data_o, held_d);
            check("t2.hold_last", bus.data_last_o, held_l);
         end
         bus.data_ready_i = (cyc % 2 == 0);
         held_v = 1'b0;
         if (bus.data_valid_o) begin
            if (bus.data_ready_i) begin
               check($sformatf("t2.data[%0d]", k), bus.data_o, ord(k));
               check($sformatf("t2.last[%0d]", k), bus.data_last_o, (k == NA - 1));
               k++;
            end else begin
               held_d = bus.data_o;
               held_l = bus.data_last_o;
               held_v = 1'b1;
            end
         end
         tick();
         cyc++;
      end
      bus.data_ready_i = 1'b1;
      check("t2.count", k, NA);
      check("t2.valid_end", bus.data_valid_o, 0);

      // Back-to-back vectors stream without a bubble
      strobe(0);
      stream("t3a", 0, NA, 0, 100);
      stream("t3b", 100, NA, -1, 0);
      check("t3.valid_end", bus.data_valid_o, 0);
      check("t3.ovf", overflow_o, 0);

      // Third vector while both slots are full is dropped
      bus.data_ready_i = 1'b0;
      strobe(0);
      strobe(100);
      strobe(300);
      check("t4.ovf", overflow_o, 1);
      check("t4.busy", busy_o, 1);
      check("t4.stall_data", bus.data_o, ord(0));
      tick();
      tick();
      check("t4.ovf_sticky", overflow_o, 1);
      bus.data_ready_i = 1'b1;
      stream("t4a", 0, NA, -1, 0);
      stream("t4b", 100, NA, -1, 0);
      check("t4.valid_end", bus.data_valid_o, 0);
      check("t4.ovf_hold", overflow_o, 1);

      // Strobe on A's final transfer with pending empty
      do_reset();
      check("t5.ovf_clr", overflow_o, 0);
      strobe(0);
      stream("t5a", 0, NA, NA - 1, 200);
      stream("t5b", 200, NA, -1, 0);
      check("t5.ovf", overflow_o, 0);
      check("t5.valid_end", bus.data_valid_o, 0);

      // Reset mid-stream with B pending; a strobe during reset is ignored
      strobe(0);
      stream("t6a", 0, 4, 0, 100);
      rst_i        = 1'b1;
      data_i       = mkvec(300);
      data_valid_i = 1'b1;
      tick();
      rst_i        = 1'b0;
      data_valid_i = 1'b0;
      check("t6.valid", bus.data_valid_o, 0);
      check("t6.busy", busy_o, 0);
      check("t6.ovf", overflow_o, 0);
      check("t6.last", bus.data_last_o, 0);
      check("t6.data", bus.data_o, 0);
      tick();
      check("t6.valid_idle", bus.data_valid_o, 0);
      strobe(500);
      stream("t6b", 500, NA, -1, 0);
      check("t6.valid_end", bus.data_valid_o, 0);
      check("t6.busy_end", busy_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
